// File: rtl/mb_pkg.sv
// mb_pkg: shared definitions for the Modbus serial transmit path.
// Holds the transmit FSM state encoding, the Modbus CRC-16 constants,
// the RTU minimum turnaround (3.5 characters in Q8.8) and the ASCII
// framing characters.
package mb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_GAP   = 4'd1,
    ST_LEAD  = 4'd2,
    ST_HDR   = 4'd3,
    ST_FETCH = 4'd4,
    ST_CAPT  = 4'd5,
    ST_SEND  = 4'd6,
    ST_TRL   = 4'd7,
    ST_TAIL  = 4'd8,
    ST_DONE  = 4'd9
  } mb_state_e;

  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'hA001;
  localparam logic [15:0] Q88_MIN_RTU = 16'h0380;
  localparam logic [7:0]  ASCII_COLON = 8'h3A;
  localparam logic [7:0]  ASCII_CR    = 8'h0D;
  localparam logic [7:0]  ASCII_LF    = 8'h0A;

endpackage

// File: rtl/mb_crc16_byte.sv
// mb_crc16_byte: combinational Modbus CRC-16 update for one byte
// (reflected polynomial, LSB first).
// Ports: crc_i  - running CRC before the byte
//        byte_i - data byte folded into the CRC
//        crc_o  - running CRC after the byte
module mb_crc16_byte
  import mb_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o
);

  logic [15:0] stage_s [0:8];

  // One shift/xor step of the reflected CRC.
  function automatic logic [15:0] crc_step(input logic [15:0] c);
    if (c[0]) begin
      crc_step = {1'b0, c[15:1]} ^ CRC_POLY;
    end else begin
      crc_step = {1'b0, c[15:1]};
    end
  endfunction

  assign stage_s[0] = crc_i ^ {8'h00, byte_i};

  for (genvar g = 0; g < 8; g++) begin : g_step
    assign stage_s[g + 1] = crc_step(stage_s[g]);
  end

  assign crc_o = stage_s[8];

endmodule

// File: rtl/mb_tx_sched.sv
// mb_tx_sched: Modbus transmit scheduler. Waits out the turnaround silence,
// raises the RS-485 driver enable, reads the payload from the frame buffer
// and emits an RTU (payload + CRC-16) or ASCII (':' hex payload LRC CR LF)
// frame over a valid/ready byte stream, then holds DE for one character
// plus a margin before releasing the line.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start_i, len_i, ascii_en,
//   char_clks, turn_q88        frame request and its parameters
//   rx_busy_i                  receive activity, restarts the silence count
//   abort_i                    stop the frame and release the line
//   buf_addr_o/buf_rd_o/buf_data_i  payload buffer read port (1-cycle latency)
//   tx_data_o/tx_valid_o/tx_ready_i byte stream to the UART bridge
//   de_o, busy_o               driver enable, frame in progress
//   done_o, aborted_o, err_o   completion pulse, abort qualifier, len=0 error
module mb_tx_sched
  import mb_pkg::*;
#(
  parameter int DE_LEAD       = 8,
  parameter int DE_TAIL_EXTRA = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [8:0]  len_i,
  input  logic        ascii_en,
  input  logic [31:0] char_clks,
  input  logic [15:0] turn_q88,
  input  logic        rx_busy_i,
  input  logic        abort_i,
  output logic [7:0]  buf_addr_o,
  output logic        buf_rd_o,
  input  logic [7:0]  buf_data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        de_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o,
  output logic        err_o
);

  mb_state_e   state_q, state_d;
  logic [32:0] cnt_q, cnt_d;
  logic [31:0] thr_q, thr_d, char_clks_q, char_clks_d;
  logic [8:0]  len_q, len_d, idx_q, idx_d;
  logic        ascii_q, ascii_d, nib_q, nib_d, abort_q, abort_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  sum_q, sum_d, byte_q, byte_d;
  logic [1:0]  trl_q, trl_d;
  logic [7:0]  buf_addr_q, buf_addr_d, tx_data_q, tx_data_d;
  logic        buf_rd_q, buf_rd_d, tx_valid_q, tx_valid_d;
  logic        de_q, de_d, busy_q, busy_d, done_q, done_d;
  logic        aborted_q, aborted_d, err_q, err_d;

  logic [15:0] turn_eff_s, crc_next_s;
  logic [47:0] prod_s;
  logic [31:0] thr_s;
  logic [32:0] tail_len_s;
  logic [7:0]  lrc_s;
  logic [1:0]  trl_last_s;
  logic        xfer_s, post_lead_s;

  // Nibble to uppercase hex ASCII.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      hex_char = 8'h30 + {4'h0, n};
    end else begin
      hex_char = 8'h37 + {4'h0, n};
    end
  endfunction

  // k-th trailer character: CRC lo/hi for RTU; LRC hex, CR, LF for ASCII.
  function automatic logic [7:0] trailer_char(input logic asc, input logic [1:0] k,
                                              input logic [15:0] crc, input logic [7:0] lrc);
    case (k)
      2'd0:    trailer_char = asc ? hex_char(lrc[7:4]) : crc[7:0];
      2'd1:    trailer_char = asc ? hex_char(lrc[3:0]) : crc[15:8];
      2'd2:    trailer_char = ASCII_CR;
      2'd3:    trailer_char = ASCII_LF;
      default: trailer_char = 8'h00;
    endcase
  endfunction

  mb_crc16_byte u_crc (
    .crc_i  (crc_q),
    .byte_i (buf_data_i),
    .crc_o  (crc_next_s)
  );

  // Turnaround threshold for a start request; RTU never goes below 3.5 chars.
  always_comb begin
    if (!ascii_en && (turn_q88 < Q88_MIN_RTU)) begin
      turn_eff_s = Q88_MIN_RTU;
    end else begin
      turn_eff_s = turn_q88;
    end
    prod_s = {32'h0000_0000, turn_eff_s} * {16'h0000, char_clks};
    thr_s  = 32'(prod_s >> 8'd8);
  end

  assign xfer_s      = tx_valid_q & tx_ready_i;
  assign tail_len_s  = {1'b0, char_clks_q} + 33'(DE_TAIL_EXTRA);
  assign lrc_s       = 8'h00 - sum_q;
  assign trl_last_s  = ascii_q ? 2'd3 : 2'd1;
  assign post_lead_s = (state_q == ST_HDR) || (state_q == ST_FETCH) || (state_q == ST_CAPT) ||
                       (state_q == ST_SEND) || (state_q == ST_TRL);

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    thr_d       = thr_q;
    char_clks_d = char_clks_q;
    len_d       = len_q;
    idx_d       = idx_q;
    ascii_d     = ascii_q;
    nib_d       = nib_q;
    crc_d       = crc_q;
    sum_d       = sum_q;
    byte_d      = byte_q;
    trl_d       = trl_q;
    buf_addr_d  = buf_addr_q;
    buf_rd_d    = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    de_d        = de_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    err_d       = 1'b0;
    // A late abort is remembered until the in-flight handshake finishes.
    abort_d     = abort_q | (abort_i & post_lead_s);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        de_d    = 1'b0;
        if (start_i) begin
          if (len_i == 9'd0) begin
            err_d = 1'b1;
          end else begin
            ascii_d     = ascii_en;
            len_d       = len_i;
            char_clks_d = char_clks;
            thr_d       = thr_s;
            crc_d       = CRC_INIT;
            sum_d       = 8'h00;
            idx_d       = 9'd0;
            cnt_d       = 33'd0;
            abort_d     = 1'b0;
            busy_d      = 1'b1;
            state_d     = ST_GAP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (abort_i) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
        end else if (rx_busy_i) begin
          cnt_d = 33'd0;
        end else if (cnt_q >= {1'b0, thr_q}) begin
          state_d = ST_LEAD;
          cnt_d   = 33'd0;
          de_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 33'd1;
        end
      end
      ST_LEAD: begin
        if (abort_i) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          de_d      = 1'b0;
        end else if ((cnt_q + 33'd1) >= 33'(DE_LEAD)) begin
          cnt_d = 33'd0;
          if (ascii_q) begin
            state_d    = ST_HDR;
            tx_valid_d = 1'b1;
            tx_data_d  = ASCII_COLON;
          end else begin
            state_d    = ST_FETCH;
            buf_rd_d   = 1'b1;
            buf_addr_d = idx_q[7:0];
          end
        end else begin
          cnt_d = cnt_q + 33'd1;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          tx_valid_d = 1'b0;
          if (abort_d) begin
            state_d = ST_TAIL;
            cnt_d   = 33'd0;
          end else begin
            state_d    = ST_FETCH;
            buf_rd_d   = 1'b1;
            buf_addr_d = idx_q[7:0];
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_FETCH: begin
        cnt_d = 33'd0;
        if (abort_d) begin
          state_d = ST_TAIL;
        end else begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        byte_d = buf_data_i;
        if (ascii_q) begin
          sum_d = sum_q + buf_data_i;
        end else begin
          crc_d = crc_next_s;
        end
        if (abort_d) begin
          state_d = ST_TAIL;
          cnt_d   = 33'd0;
        end else begin
          state_d    = ST_SEND;
          nib_d      = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = ascii_q ? hex_char(buf_data_i[7:4]) : buf_data_i;
        end
      end
      ST_SEND: begin
        if (xfer_s) begin
          if (ascii_q && !nib_q && !abort_d) begin
            nib_d     = 1'b1;
            tx_data_d = hex_char(byte_q[3:0]);
          end else begin
            tx_valid_d = 1'b0;
            idx_d      = idx_q + 9'd1;
            if (abort_d) begin
              state_d = ST_TAIL;
              cnt_d   = 33'd0;
            end else if ((idx_q + 9'd1) < len_q) begin
              state_d    = ST_FETCH;
              buf_rd_d   = 1'b1;
              buf_addr_d = idx_d[7:0];
            end else begin
              state_d    = ST_TRL;
              trl_d      = 2'd0;
              tx_valid_d = 1'b1;
              tx_data_d  = trailer_char(ascii_q, 2'd0, crc_q, lrc_s);
            end
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_TRL: begin
        if (xfer_s) begin
          if (abort_d || (trl_q == trl_last_s)) begin
            state_d    = ST_TAIL;
            tx_valid_d = 1'b0;
            cnt_d      = 33'd0;
          end else begin
            trl_d     = trl_q + 2'd1;
            tx_data_d = trailer_char(ascii_q, trl_q + 2'd1, crc_q, lrc_s);
          end
        end else begin
          state_d = ST_TRL;
        end
      end
      ST_TAIL: begin
        if ((cnt_q + 33'd1) >= tail_len_s) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = abort_q;
          de_d      = 1'b0;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 33'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 33'd0;
      thr_q       <= 32'd0;
      char_clks_q <= 32'd0;
      len_q       <= 9'd0;
      idx_q       <= 9'd0;
      ascii_q     <= 1'b0;
      nib_q       <= 1'b0;
      abort_q     <= 1'b0;
      crc_q       <= CRC_INIT;
      sum_q       <= 8'h00;
      byte_q      <= 8'h00;
      trl_q       <= 2'd0;
      buf_addr_q  <= 8'h00;
      buf_rd_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      de_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      thr_q       <= thr_d;
      char_clks_q <= char_clks_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      ascii_q     <= ascii_d;
      nib_q       <= nib_d;
      abort_q     <= abort_d;
      crc_q       <= crc_d;
      sum_q       <= sum_d;
      byte_q      <= byte_d;
      trl_q       <= trl_d;
      buf_addr_q  <= buf_addr_d;
      buf_rd_q    <= buf_rd_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      de_q        <= de_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
    end
  end

  assign buf_addr_o = buf_addr_q;
  assign buf_rd_o   = buf_rd_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign de_o       = de_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign aborted_o  = aborted_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mb_tx_sched.sv
// tb_mb_tx_sched: directed self-checking bench for mb_tx_sched.
module tb_mb_tx_sched;

  logic        clk, rst, start_i, ascii_en, rx_busy_i, abort_i;
  logic [8:0]  len_i;
  logic [31:0] char_clks;
  logic [15:0] turn_q88;
  logic [7:0]  buf_addr_o, buf_data_i, tx_data_o;
  logic        buf_rd_o, tx_valid_o, tx_ready_i;
  logic        de_o, busy_o, done_o, aborted_o, err_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0] mem    [0:255];
  logic [7:0] cap    [0:2047];
  logic [7:0] rd_log [0:2047];
  int cap_n = 0, rd_n = 0, done_n = 0, de_hi_n = 0, stab_bad = 0;
  bit stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  mb_tx_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .ascii_en(ascii_en),
    .char_clks(char_clks), .turn_q88(turn_q88), .rx_busy_i(rx_busy_i), .abort_i(abort_i),
    .buf_addr_o(buf_addr_o), .buf_rd_o(buf_rd_o), .buf_data_i(buf_data_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .de_o(de_o), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (buf_rd_o) buf_data_i <= mem[buf_addr_o];
  end

  // Observers on the falling edge: transfers, reads, pulses, stability.
  always @(negedge clk) begin
    if (tx_valid_o && tx_ready_i) begin
      if (cap_n < 2048) cap[cap_n] = tx_data_o;
      cap_n++;
    end
    if (buf_rd_o) begin
      if (rd_n < 2048) rd_log[rd_n] = buf_addr_o;
      rd_n++;
    end
    if (done_o) done_n++;
    if (de_o) de_hi_n++;
    if (!rst && stall_prev && (!tx_valid_o || tx_data_o !== data_prev)) stab_bad++;
    stall_prev = !rst && tx_valid_o && !tx_ready_i;
    data_prev  = tx_data_o;
  end

  task automatic do_start(input logic [8:0] len, input logic asc, input logic [31:0] cc,
                          input logic [15:0] tq);
    start_i = 1'b1; len_i = len; ascii_en = asc; char_clks = cc; turn_q88 = tq;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (done_o) begin seen = 1'b1; break; end
      if (rnd) tx_ready_i = ($urandom_range(0, 99) < 30);
    end
    tx_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({de_o, busy_o, done_o, aborted_o, err_o, tx_valid_o, buf_rd_o} !== 7'd0)
      $display("FAIL reset_ctrl: got %b want 0000000",
               {de_o, busy_o, done_o, aborted_o, err_o, tx_valid_o, buf_rd_o});
    else pass_cnt++;
    chk_cnt++;
    if ({tx_data_o, buf_addr_o} !== 16'h0000)
      $display("FAIL reset_data: got %h want 0000", {tx_data_o, buf_addr_o});
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rtu_frame();
    logic [7:0] exp_b [0:7];
    int base, dn, n;
    bit seen;
    exp_b = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    for (int i = 0; i < 6; i++) mem[i] = exp_b[i];
    base = cap_n; dn = done_n;
    do_start(9'd6, 1'b0, 32'd10, 16'h0000);
    n = 0;
    while (!de_o && n < 200) begin @(posedge clk); #1; n++; end
    chk_cnt++;
    if (n !== 36) $display("FAIL rtu_start_to_de: got %0d want 36", n); else pass_cnt++;
    n = 0;
    while (!tx_valid_o && n < 200) begin @(posedge clk); #1; n++; end
    chk_cnt++;
    if (n !== 10) $display("FAIL rtu_de_to_first_byte: got %0d want 10", n); else pass_cnt++;
    wait_done(3000, 1'b0, seen);
    chk_cnt++;
    if (seen !== 1'b1 || aborted_o !== 1'b0)
      $display("FAIL rtu_done: done %0b aborted %0b want 1 0", seen, aborted_o);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (cap_n - base !== 8) $display("FAIL rtu_count: got %0d want 8", cap_n - base); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (cap[base + i] !== exp_b[i])
        $display("FAIL rtu_byte%0d: got %h want %h", i, cap[base + i], exp_b[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (done_n - dn !== 1) $display("FAIL rtu_done_pulses: got %0d want 1", done_n - dn); else pass_cnt++;
  endtask

  task automatic test_ascii_frame();
    logic [7:0] exp_b [0:16];
    int base, n;
    bit seen;
    exp_b = '{8'h3A, 8'h30, 8'h31, 8'h30, 8'h33, 8'h30, 8'h30, 8'h30, 8'h30,
              8'h30, 8'h30, 8'h30, 8'h31, 8'h46, 8'h42, 8'h0D, 8'h0A};
    base = cap_n;
    do_start(9'd6, 1'b1, 32'd10, 16'h0000);
    n = 0;
    while (!de_o && n < 200) begin @(posedge clk); #1; n++; end
    chk_cnt++;
    if (n !== 1) $display("FAIL ascii_start_to_de: got %0d want 1", n); else pass_cnt++;
    n = 0;
    while (!tx_valid_o && n < 200) begin @(posedge clk); #1; n++; end
    chk_cnt++;
    if (n !== 8) $display("FAIL ascii_de_to_colon: got %0d want 8", n); else pass_cnt++;
    wait_done(3000, 1'b0, seen);
    chk_cnt++;
    if (seen !== 1'b1 || aborted_o !== 1'b0)
      $display("FAIL ascii_done: done %0b aborted %0b want 1 0", seen, aborted_o);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (cap_n - base !== 17) $display("FAIL ascii_count: got %0d want 17", cap_n - base); else pass_cnt++;
    for (int i = 0; i < 17; i++) begin
      chk_cnt++;
      if (cap[base + i] !== exp_b[i])
        $display("FAIL ascii_byte%0d: got %h want %h", i, cap[base + i], exp_b[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_threshold_clamp();
    int n;
    bit seen;
    mem[0] = 8'h5A;
    do_start(9'd1, 1'b0, 32'd100, 16'h0100);
    repeat (200) @(posedge clk);
    #1;
    chk_cnt++;
    if (de_o !== 1'b0) $display("FAIL clamp_de_early: got %0b want 0", de_o); else pass_cnt++;
    rx_busy_i = 1'b1;
    @(posedge clk); #1;
    rx_busy_i = 1'b0;
    n = 0;
    while (!de_o && n < 1000) begin @(posedge clk); #1; n++; end
    chk_cnt++;
    if (n !== 351) $display("FAIL clamp_busy_to_de: got %0d want 351", n); else pass_cnt++;
    wait_done(3000, 1'b0, seen);
    chk_cnt++;
    if (seen !== 1'b1) $display("FAIL clamp_done: got %0b want 1", seen); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_len256_backpressure();
    logic [15:0] crc;
    int base, rbase, sb, bad, abad;
    bit seen;
    crc = 16'hFFFF;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'((i * 37) + 5);
      crc = crc ^ {8'h00, mem[i]};
      for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
    end
    base = cap_n; rbase = rd_n; sb = stab_bad;
    tx_ready_i = 1'b0;
    do_start(9'h100, 1'b0, 32'd4, 16'h0000);
    wait_done(20000, 1'b1, seen);
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (seen !== 1'b1) $display("FAIL l256_done: got %0b want 1", seen); else pass_cnt++;
    chk_cnt++;
    if (cap_n - base !== 258) $display("FAIL l256_count: got %0d want 258", cap_n - base); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 256; i++) if (cap[base + i] !== mem[i]) bad++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL l256_payload: got %0d bad bytes want 0", bad); else pass_cnt++;
    chk_cnt++;
    if ({cap[base + 257], cap[base + 256]} !== crc)
      $display("FAIL l256_crc: got %h%h want %h", cap[base + 257], cap[base + 256], crc);
    else pass_cnt++;
    abad = 0;
    for (int i = 0; i < 256; i++) if (rd_log[rbase + i] !== 8'(i)) abad++;
    chk_cnt++;
    if (rd_n - rbase !== 256 || abad !== 0)
      $display("FAIL l256_reads: got %0d reads %0d bad addr want 256 0", rd_n - rbase, abad);
    else pass_cnt++;
    chk_cnt++;
    if (stab_bad - sb !== 0) $display("FAIL l256_stable: got %0d violations want 0", stab_bad - sb);
    else pass_cnt++;
  endtask

  task automatic test_err_and_ignore();
    int base, dn;
    bit seen;
    do_start(9'd0, 1'b0, 32'd4, 16'h0000);
    chk_cnt++;
    if ({err_o, busy_o, de_o} !== 3'b100)
      $display("FAIL err_pulse: got %b want 100", {err_o, busy_o, de_o});
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({err_o, busy_o, de_o} !== 3'b000)
      $display("FAIL err_one_cycle: got %b want 000", {err_o, busy_o, de_o});
    else pass_cnt++;
    mem[0] = 8'hAA; mem[1] = 8'hBB;
    base = cap_n; dn = done_n;
    do_start(9'd1, 1'b0, 32'd4, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    do_start(9'd2, 1'b0, 32'd4, 16'h0000);
    wait_done(2000, 1'b0, seen);
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (cap_n - base !== 3 || cap[base] !== 8'hAA)
      $display("FAIL ignore_start: got %0d bytes first %h want 3 aa", cap_n - base, cap[base]);
    else pass_cnt++;
    chk_cnt++;
    if (done_n - dn !== 1) $display("FAIL ignore_done: got %0d want 1", done_n - dn); else pass_cnt++;
  endtask

  task automatic test_abort_gap();
    int base, dh;
    base = cap_n; dh = de_hi_n;
    do_start(9'd1, 1'b0, 32'd100, 16'h0000);
    repeat (20) @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk_cnt++;
    if ({done_o, aborted_o} !== 2'b11)
      $display("FAIL gap_abort_done: got %b want 11", {done_o, aborted_o});
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({done_o, aborted_o, busy_o} !== 3'b000)
      $display("FAIL gap_abort_after: got %b want 000", {done_o, aborted_o, busy_o});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (de_hi_n - dh !== 0 || cap_n - base !== 0)
      $display("FAIL gap_abort_line: got de %0d bytes %0d want 0 0", de_hi_n - dh, cap_n - base);
    else pass_cnt++;
  endtask

  task automatic test_abort_send();
    int base, n;
    bit vflag, dropflag;
    mem[0] = 8'h01; mem[1] = 8'h03;
    base = cap_n;
    tx_ready_i = 1'b0;
    do_start(9'd6, 1'b0, 32'd20, 16'h0000);
    n = 0;
    while (!tx_valid_o && n < 500) begin @(posedge clk); #1; n++; end
    chk_cnt++;
    if (tx_valid_o !== 1'b1) $display("FAIL send_offer: got %0b want 1", tx_valid_o); else pass_cnt++;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    tx_ready_i = 1'b1;
    @(posedge clk); #1;
    n = 0; vflag = 1'b0; dropflag = 1'b0;
    while (!done_o && n < 500) begin
      @(posedge clk); #1;
      n++;
      if (tx_valid_o) vflag = 1'b1;
      if (!done_o && !de_o) dropflag = 1'b0 | 1'b1;
    end
    chk_cnt++;
    if (n !== 24) $display("FAIL send_tail_len: got %0d want 24", n); else pass_cnt++;
    chk_cnt++;
    if ({aborted_o, vflag, dropflag} !== 3'b100)
      $display("FAIL send_abort_flags: got %b want 100", {aborted_o, vflag, dropflag});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (cap_n - base !== 1 || cap[base] !== 8'h01)
      $display("FAIL send_abort_bytes: got %0d first %h want 1 01", cap_n - base, cap[base]);
    else pass_cnt++;
    chk_cnt++;
    if (de_o !== 1'b0) $display("FAIL send_abort_de_off: got %0b want 0", de_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int n, dh;
    do_start(9'd2, 1'b1, 32'd4, 16'h0000);
    n = 0;
    while (!de_o && n < 50) begin @(posedge clk); #1; n++; end
    chk_cnt++;
    if (de_o !== 1'b1) $display("FAIL mid_de_up: got %0b want 1", de_o); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({de_o, busy_o, tx_valid_o, buf_rd_o} !== 4'b0000)
      $display("FAIL mid_reset_drop: got %b want 0000", {de_o, busy_o, tx_valid_o, buf_rd_o});
    else pass_cnt++;
    rst = 1'b0;
    dh = de_hi_n;
    repeat (30) @(posedge clk);
    #1;
    chk_cnt++;
    if (de_hi_n - dh !== 0) $display("FAIL mid_no_tail: got %0d want 0", de_hi_n - dh); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; len_i = 9'd0; ascii_en = 1'b0; char_clks = 32'd0;
    turn_q88 = 16'h0000; rx_busy_i = 1'b0; abort_i = 1'b0; tx_ready_i = 1'b1;
    buf_data_i = 8'h00;
    test_reset();
    test_rtu_frame();
    test_ascii_frame();
    test_threshold_clamp();
    test_len256_backpressure();
    test_err_and_ignore();
    test_abort_gap();
    test_abort_send();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
